// File: rtl/pipe_backbone.sv
// pipe_backbone: in-order stall/flush pipeline with forwarding lookup (comparators built only when PIPE_FWD_EN is defined)
module pipe_backbone #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int RW    = 5,
    parameter int NSRC  = 2,
    parameter int SW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [RW-1:0]           in_wreg,
    input  logic                    in_we,
    output logic                    in_ready,
    input  logic [DEPTH-1:0]        stall_req,
    input  logic [DEPTH-1:0]        flush_req,
    output logic [DEPTH-1:0]        stall_o,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [DEPTH*WIDTH-1:0]  stage_data,
    output logic [DEPTH*RW-1:0]     stage_wreg,
    output logic [DEPTH-1:0]        stage_we,
    output logic                    out_fire,
    input  logic [NSRC*RW-1:0]      fwd_src,
    output logic [NSRC-1:0]         fwd_hit,
    output logic [NSRC*SW-1:0]      fwd_stage,
    output logic [NSRC*WIDTH-1:0]   fwd_data
);
    logic [DEPTH-1:0]            r_valid, r_we;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0][RW-1:0]    r_wreg;
    logic [DEPTH-1:0]            w_kill, w_adv, w_sv, w_se;
    logic [DEPTH-1:0][WIDTH-1:0] w_sd;
    logic [DEPTH-1:0][RW-1:0]    w_sw;
    for (genvar k = 0; k < DEPTH; k++) begin : g_res
        assign stall_o[k] = |stall_req[DEPTH-1:k];
        assign w_kill[k]  = |flush_req[DEPTH-1:k];
    end
    assign in_ready = ~stall_o[0] & ~|flush_req;
    // each stage's source is the stage below it; stage 0 sources the input port
    assign w_adv = {~stall_o[DEPTH-2:0], in_valid & in_ready};
    assign w_sv  = {r_valid[DEPTH-2:0], 1'b1};
    assign w_se  = {r_we[DEPTH-2:0], in_we};
    assign w_sd  = {r_data[DEPTH-2:0], in_data};
    assign w_sw  = {r_wreg[DEPTH-2:0], in_wreg};
    always_ff @(posedge clk)
        for (int k = 0; k < DEPTH; k++)
            if (rst || w_kill[k] || (!stall_o[k] && !w_adv[k])) begin
                r_valid[k] <= 1'b0;
                r_we[k]    <= 1'b0;
                r_data[k]  <= '0;
                r_wreg[k]  <= '0;
            end else if (!stall_o[k]) begin
                r_valid[k] <= w_sv[k];
                r_we[k]    <= w_se[k];
                r_data[k]  <= w_sd[k];
                r_wreg[k]  <= w_sw[k];
            end
    assign stage_valid = r_valid;
    assign stage_we    = r_we;
    assign stage_data  = r_data;
    assign stage_wreg  = r_wreg;
    assign out_fire    = r_valid[DEPTH-1] & ~stall_o[DEPTH-1];
`ifdef PIPE_FWD_EN
    // scan oldest to youngest so the youngest match overwrites
    always_comb begin
        fwd_hit   = '0;
        fwd_stage = '0;
        fwd_data  = '0;
        for (int i = 0; i < NSRC; i++)
            for (int k = DEPTH - 1; k >= 0; k--)
                if (r_valid[k] && r_we[k] && fwd_src[i*RW +: RW] != '0 && r_wreg[k] == fwd_src[i*RW +: RW]) begin
                    fwd_hit[i]             = 1'b1;
                    fwd_stage[i*SW +: SW]  = SW'(k);
                    fwd_data[i*WIDTH +: WIDTH] = r_data[k];
                end
    end
`else
    logic w_unused;
    assign w_unused  = ^fwd_src;
    assign fwd_hit   = '0;
    assign fwd_stage = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_pipe_backbone.sv
// tb_pipe_backbone: randomized and directed checks of pipe_backbone against a stage-occupancy model
module tb_pipe_backbone;
    localparam int D = 4, W = 32, RW = 5, NS = 2, SW = 2;
    logic clk = 0, rst = 1, in_valid = 0, in_we = 0;
    logic [W-1:0] in_data = '0;
    logic [RW-1:0] in_wreg = '0;
    logic [D-1:0] stall_req = '0, flush_req = '0;
    logic [NS*RW-1:0] fwd_src = '0;
    logic in_ready, out_fire;
    logic [D-1:0] stall_o, stage_valid, stage_we;
    logic [D*W-1:0] stage_data;
    logic [D*RW-1:0] stage_wreg;
    logic [NS-1:0] fwd_hit;
    logic [NS*SW-1:0] fwd_stage;
    logic [NS*W-1:0] fwd_data;

    pipe_backbone #(.DEPTH(D), .WIDTH(W), .RW(RW), .NSRC(NS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_wreg(in_wreg),
        .in_we(in_we), .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
        .stall_o(stall_o), .stage_valid(stage_valid), .stage_data(stage_data),
        .stage_wreg(stage_wreg), .stage_we(stage_we), .out_fire(out_fire),
        .fwd_src(fwd_src), .fwd_hit(fwd_hit), .fwd_stage(fwd_stage), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit started = 0;
    logic mv[D], me[D];
    logic [W-1:0] md[D];
    logic [RW-1:0] mw[D];
    int ms, mf;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int top_idx(input logic [D-1:0] v);
        int r = -1;
        for (int k = 0; k < D; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic m_clr(input int k);
        mv[k] = 0; me[k] = 0; md[k] = '0; mw[k] = '0;
    endtask

    // Model: highest stall index s freezes 0..s, s+1 gets a bubble, above shifts; highest flush f empties 0..f
    always @(posedge clk) begin
        ms = top_idx(stall_req);
        mf = top_idx(flush_req);
        for (int k = D - 1; k >= 0; k--) begin
            if (rst || k <= mf) m_clr(k);
            else if (k <= ms) begin end
            else if (ms >= 0 && k == ms + 1) m_clr(k);
            else if (k > 0) begin
                mv[k] = mv[k-1]; me[k] = me[k-1]; md[k] = md[k-1]; mw[k] = mw[k-1];
            end else if (in_valid) begin
                mv[0] = 1; me[0] = in_we; md[0] = in_data; mw[0] = in_wreg;
            end else m_clr(0);
        end
        started = 1;
    end

    always @(negedge clk) if (started) begin
        logic [D-1:0] ev, ee, es;
        logic [D*W-1:0] ed;
        logic [D*RW-1:0] ew;
        logic [NS-1:0] eh;
        logic [NS*SW-1:0] est;
        logic [NS*W-1:0] efd;
        int s;
        s = top_idx(stall_req);
        for (int k = 0; k < D; k++) begin
            ev[k] = mv[k]; ee[k] = me[k]; ed[k*W +: W] = md[k]; ew[k*RW +: RW] = mw[k];
            es[k] = s >= k;
        end
        eh = '0; est = '0; efd = '0;
`ifdef PIPE_FWD_EN
        for (int i = 0; i < NS; i++)
            for (int k = 0; k < D; k++)
                if (!eh[i] && mv[k] && me[k] && fwd_src[i*RW +: RW] != 0 && mw[k] == fwd_src[i*RW +: RW]) begin
                    eh[i] = 1; est[i*SW +: SW] = SW'(k); efd[i*W +: W] = md[k];
                end
`endif
        chk("valid", stage_valid, ev);
        chk("we", stage_we, ee);
        chk("data", stage_data, ed);
        chk("wreg", stage_wreg, ew);
        chk("stall_o", stall_o, es);
        chk("in_ready", in_ready, stall_req == 0 && flush_req == 0);
        chk("out_fire", out_fire, mv[D-1] && !stall_req[D-1]);
        chk("fwd_hit", fwd_hit, eh);
        chk("fwd_stage", fwd_stage, est);
        chk("fwd_data", fwd_data, efd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [W-1:0] d, input logic [RW-1:0] r, input logic e);
        in_valid = v; in_data = d; in_wreg = r; in_we = e;
        step();
    endtask

    task automatic fwd_scene(input logic we1);
        push(1, 32'hB, 8, 1);
        push(1, 32'h5, 3, 1);
        push(1, 32'hA, 8, we1);
        push(1, 32'h7, 2, 1);
        in_valid = 0;
        fwd_src = {5'd0, 5'd8};
        #1;
    endtask

    initial begin
        step(); step();
        rst = 0;
        chk("rst_valid", stage_valid, 4'b0000);
        chk("rst_data", stage_data, '0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_stall", stall_o, 4'b0000);
        // stream 0x11..0x16
        for (int i = 0; i < 10; i++) begin
            push(i < 6, 32'h11 + i, 5'(i + 1), 1);
            chk("stream_fire", out_fire, i >= 3 && i <= 8);
            if (i >= 3 && i <= 8) chk("stream_ret", stage_data[3*W +: W], 32'h11 + i - 3);
        end
        // stall stage 2 for 3 cycles mid-stream
        for (int i = 0; i < 4; i++) push(1, 32'h21 + i, 1, 1);
        stall_req = 4'b0100;
        #1;
        chk("stall_ready", in_ready, 1'b0);
        chk("stall_o", stall_o, 4'b0111);
        push(1, 32'h25, 1, 1);
        chk("bubble_v", stage_valid[3], 1'b0);
        chk("bubble_d", stage_data[3*W +: W], 32'h0);
        chk("held_s2", stage_data[2*W +: W], 32'h22);
        push(1, 32'h25, 1, 1);
        push(1, 32'h25, 1, 1);
        stall_req = 0;
        for (int i = 0; i < 6; i++) push(1, 32'h25 + i, 1, 1);
        // flush stage 2 with stall stage 3
        for (int i = 0; i < 4; i++) push(1, 32'h31 + i, 1, 1);
        flush_req = 4'b0100; stall_req = 4'b1000;
        #1;
        chk("fs_ready", in_ready, 1'b0);
        push(1, 32'h99, 1, 1);
        chk("fs_valid", stage_valid, 4'b1000);
        chk("fs_hold", stage_data[3*W +: W], 32'h31);
        flush_req = 0; stall_req = 0;
        step();
        // forwarding
        fwd_scene(1);
`ifdef PIPE_FWD_EN
        chk("fwd_lit_hit", fwd_hit, 2'b01);
        chk("fwd_lit_stage", fwd_stage[1:0], 2'd1);
        chk("fwd_lit_data", fwd_data[W-1:0], 32'hA);
`else
        chk("fwd_off_hit", fwd_hit, 2'b00);
        chk("fwd_off_data", fwd_data, '0);
`endif
        fwd_scene(0);
`ifdef PIPE_FWD_EN
        chk("fwd_lit_stage3", fwd_stage[1:0], 2'd3);
        chk("fwd_lit_data3", fwd_data[W-1:0], 32'hB);
`else
        chk("fwd_off_hit2", fwd_hit, 2'b00);
`endif
        // reset mid-operation with stage 3 stalled
        for (int i = 0; i < 4; i++) push(1, 32'h41 + i, 1, 1);
        stall_req = 4'b1000; rst = 1;
        step();
        chk("mrst_valid", stage_valid, 4'b0000);
        chk("mrst_data", stage_data, '0);
        chk("mrst_fire", out_fire, 1'b0);
        rst = 0; stall_req = 0;
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall_req = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0;
            flush_req = ($urandom_range(9) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0;
            rst       = $urandom_range(60) == 0;
            fwd_src   = {5'($urandom_range(7)), 5'($urandom_range(7))};
            push($urandom_range(3) != 0, $urandom, 5'($urandom_range(7)), 1'($urandom));
        end
        rst = 0; stall_req = 0; flush_req = 0; in_valid = 0;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
